// File: rtl/spi_fpga_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode
// constants and counter widths used by the controller and its SCLK divider.
package spi_fpga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_TRANSFER = 2'd2,
      ST_HOLD     = 2'd3
   } spi_state_e;

   // Mode constants as {CPOL, CPHA} pairs
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   // Divider counts up to CLK_DIV-1 (max 254); edge counter reaches 2*32+1
   localparam int DIV_CNT_W  = 8;
   localparam int EDGE_CNT_W = 7;

   // CPHA=0 modes capture on the leading edge, CPHA=1 modes on the trailing one
   function automatic logic sample_on_leading(input logic [1:0] mode);
      return (mode == SPI_MODE0) || (mode == SPI_MODE2);
   endfunction

endpackage

// File: rtl/spi_fpga_sclk_gen.sv
// SCLK timebase: divides the system clock by CLK_DIV while enabled, strobing
// tick_o once per CLK_DIV cycles and counting the strobes since enable.
// lead_o tells whether the strobe in progress is an odd (leading) edge.
module spi_fpga_sclk_gen
   import spi_fpga_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   output logic                  tick_o,
   output logic                  lead_o,
   output logic [EDGE_CNT_W-1:0] edge_cnt_o
);

   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

   logic [DIV_CNT_W-1:0]  div_q, div_d;
   logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o     = en_i && (div_q == DIV_LAST);
   assign lead_o     = ~cnt_q[0];
   assign edge_cnt_o = cnt_q;

   // Divider and strobe counter; both restart from zero whenever disabled
   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (!en_i) begin
         div_d = '0;
         cnt_d = '0;
      end else if (tick_o) begin
         div_d = '0;
         cnt_d = cnt_q + 1'b1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_fpga_master_ctrl.sv
// SPI master controller: one PACK_LENGTH-bit frame per accepted IN_START,
// IDLE -> SETUP -> TRANSFER -> HOLD, every output registered.
// Optional build macro SPI_FPGA_MASTER_LOOPBACK_EN: receive path samples the
// internal MOSI instead of the MISO pin.
module spi_fpga_master_ctrl
   import spi_fpga_pkg::*;
#(
   parameter int CPHA                       = 1,
   parameter int CPOL                       = 1,
   parameter int PACK_LENGTH                = 8,
   parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
   parameter int PACK_BIT_SEQUENCE_RECEIVE  = 1,
   parameter int CLK_DIV                    = 2
) (
   input  logic                   IN_CLK,
   input  logic                   IN_RESET,
   input  logic                   IN_START,
   input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
   input  logic                   MISO,
   output logic                   SCLK,
   output logic                   MOSI,
   output logic                   CS,
   output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
   output logic                   OUT_BUSY,
   output logic                   OUT_DONE
);

   localparam int                    N           = PACK_LENGTH;
   localparam logic                  CPOL_BIT    = 1'(CPOL);
   localparam logic [1:0]            MODE        = {1'(CPOL), 1'(CPHA)};
   localparam logic                  SAMPLE_LEAD = sample_on_leading(MODE);
   localparam logic [EDGE_CNT_W-1:0] LAST_EDGE   = EDGE_CNT_W'(2 * N - 1);

   spi_state_e state_q, state_d;
   logic       sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
   logic       busy_q, busy_d, done_q, done_d;
   logic [N-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
   logic [N-1:0] tx_ord, rx_ord;
   logic         rx_bit, tick, lead;
   logic [EDGE_CNT_W-1:0] edge_cnt;

`ifdef SPI_FPGA_MASTER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = MISO;
   assign rx_bit      = mosi_q;
`else
   assign rx_bit = MISO;
`endif

   // Shifters always move MSB-first; bit order is fixed up at the edges
   for (genvar i = 0; i < N; i++) begin : g_ord
      assign tx_ord[i] = (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? IN_TRANSMIT_DATA[i]
                                                           : IN_TRANSMIT_DATA[N-1-i];
      assign rx_ord[i] = (PACK_BIT_SEQUENCE_RECEIVE != 0) ? rx_q[i] : rx_q[N-1-i];
   end

   spi_fpga_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk_i      (IN_CLK),
      .rst_i      (IN_RESET),
      .en_i       (state_q != ST_IDLE),
      .tick_o     (tick),
      .lead_o     (lead),
      .edge_cnt_o (edge_cnt)
   );

   // Next-state and output decode; each divider strobe in SETUP/TRANSFER is one SCLK edge
   always_comb begin
      state_d = state_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            sclk_d = CPOL_BIT;
            mosi_d = 1'b0;
            if (IN_START) begin
               state_d = ST_SETUP;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               rx_d    = '0;
               tx_d    = tx_ord;
               // CPHA=0 presents the first bit before any clock edge
               if (SAMPLE_LEAD) begin
                  mosi_d = tx_ord[N-1];
                  tx_d   = {tx_ord[N-2:0], 1'b0};
               end
            end
         end
         ST_SETUP, ST_TRANSFER: begin
            if (tick) begin
               state_d = (edge_cnt == LAST_EDGE) ? ST_HOLD : ST_TRANSFER;
               sclk_d  = ~sclk_q;
               if (lead == SAMPLE_LEAD) begin
                  rx_d = {rx_q[N-2:0], rx_bit};
               end else if (lead || (edge_cnt != LAST_EDGE)) begin
                  mosi_d = tx_q[N-1];
                  tx_d   = {tx_q[N-2:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d = ST_IDLE;
               cs_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
               rdata_d = rx_ord;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge IN_CLK) begin
      if (IN_RESET) begin
         state_q <= ST_IDLE;
         sclk_q  <= CPOL_BIT;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
      end
   end

   assign SCLK             = sclk_q;
   assign MOSI             = mosi_q;
   assign CS               = cs_q;
   assign OUT_BUSY         = busy_q;
   assign OUT_DONE         = done_q;
   assign OUT_RECEIVE_DATA = rdata_q;

endmodule

// File: tb/tb_spi_fpga_master_ctrl.sv
// Bench for spi_fpga_master_ctrl: three masters with different modes, bit
// orders and dividers, each wired to a behavioural MSB-first slave model.
module tb_spi_fpga_master_ctrl;

   localparam int NL = 3;

   logic clk = 1'b0;
   logic rst;
   logic       start [NL];
   logic [7:0] txd   [NL];
   logic       miso  [NL];
   logic       sclk  [NL];
   logic       mosi  [NL];
   logic       cs    [NL];
   logic       busy  [NL];
   logic       done  [NL];
   logic [7:0] rxd   [NL];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // lane 0: mode 3, div 2 ; lane 1: mode 0, div 3 ; lane 2: mode 1, div 1, LSB-first both ways
   spi_fpga_master_ctrl #(.CPHA(1), .CPOL(1), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(1),
                          .PACK_BIT_SEQUENCE_RECEIVE(1), .CLK_DIV(2)) u_m0 (
      .IN_CLK(clk), .IN_RESET(rst), .IN_START(start[0]), .IN_TRANSMIT_DATA(txd[0]),
      .MISO(miso[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .CS(cs[0]),
      .OUT_RECEIVE_DATA(rxd[0]), .OUT_BUSY(busy[0]), .OUT_DONE(done[0]));

   spi_fpga_master_ctrl #(.CPHA(0), .CPOL(0), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(1),
                          .PACK_BIT_SEQUENCE_RECEIVE(1), .CLK_DIV(3)) u_m1 (
      .IN_CLK(clk), .IN_RESET(rst), .IN_START(start[1]), .IN_TRANSMIT_DATA(txd[1]),
      .MISO(miso[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .CS(cs[1]),
      .OUT_RECEIVE_DATA(rxd[1]), .OUT_BUSY(busy[1]), .OUT_DONE(done[1]));

   spi_fpga_master_ctrl #(.CPHA(1), .CPOL(0), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(0),
                          .PACK_BIT_SEQUENCE_RECEIVE(0), .CLK_DIV(1)) u_m2 (
      .IN_CLK(clk), .IN_RESET(rst), .IN_START(start[2]), .IN_TRANSMIT_DATA(txd[2]),
      .MISO(miso[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .CS(cs[2]),
      .OUT_RECEIVE_DATA(rxd[2]), .OUT_BUSY(busy[2]), .OUT_DONE(done[2]));

   function automatic logic cpha_of(input int l);  return (l != 1);  endfunction
   function automatic logic cpol_of(input int l);  return (l == 0);  endfunction
   function automatic logic txmsb_of(input int l); return (l != 2);  endfunction
   function automatic logic rxmsb_of(input int l); return (l != 2);  endfunction
   function automatic int   div_of(input int l);   return (l == 0) ? 2 : (l == 1) ? 3 : 1; endfunction

   // i-th bit on the wire for a given word
   function automatic logic seq_bit(input int l, input logic [7:0] tx, input int i);
      return txmsb_of(l) ? tx[3'(7 - i)] : tx[3'(i)];
   endfunction

   // Slave assembles incoming bits MSB-first
   function automatic logic [7:0] exp_slave(input int l, input logic [7:0] tx);
      logic [7:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[6:0], seq_bit(l, tx, i)};
      return r;
   endfunction

   // Master word: bits as they arrive, placed by the receive order
   function automatic logic [7:0] exp_master(input int l, input logic [7:0] tx, input logic [7:0] rep);
      logic [7:0] r = '0;
      logic b;
      for (int i = 0; i < 8; i++) begin
`ifdef SPI_FPGA_MASTER_LOOPBACK_EN
         b = seq_bit(l, tx, i);
`else
         b = rep[3'(7 - i)];
`endif
         if (rxmsb_of(l)) r = {r[6:0], b};
         else r[3'(i)] = b;
      end
      return r;
   endfunction

   // Slave / monitor state
   int         edges   [NL];
   int         cs_low  [NL];
   int         hi_run  [NL];
   int         last_hi [NL];
   int         done_cnt[NL];
   int         idle_bad[NL];
   int         s_idx   [NL];
   logic [7:0] s_rx    [NL];
   logic [7:0] s_reply [NL];
   logic       sclk_p  [NL];
   logic       cs_p    [NL];

   // Behavioural slave per lane plus frame statistics, evaluated mid-cycle
   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (rst) begin
            cs_p[l]   <= 1'b1;
            sclk_p[l] <= cpol_of(l);
            hi_run[l] <= 0;
            miso[l]   <= 1'b0;
         end else begin
            logic fall, mi;
            int e, idx;
            logic [7:0] srx;
            fall = cs_p[l] && !cs[l];
            e    = fall ? 0 : edges[l];
            idx  = fall ? 0 : s_idx[l];
            srx  = fall ? 8'h00 : s_rx[l];
            mi   = miso[l];
            if (fall && !cpha_of(l)) begin
               mi  = s_reply[l][7];
               idx = 1;
            end
            if (sclk[l] !== sclk_p[l]) begin
               e++;
               if (e[0] == !cpha_of(l)) srx = {srx[6:0], mosi[l]};
               else if (idx < 8) begin
                  mi = s_reply[l][3'(7 - idx)];
                  idx++;
               end
            end
            edges[l] <= e;
            s_idx[l] <= idx;
            s_rx[l]  <= srx;
            miso[l]  <= mi;
            if (fall) begin
               cs_low[l]  <= 1;
               last_hi[l] <= hi_run[l];
               hi_run[l]  <= 0;
            end else if (!cs[l]) cs_low[l] <= cs_low[l] + 1;
            else hi_run[l] <= hi_run[l] + 1;
            if (cs[l] && ((sclk[l] !== cpol_of(l)) || (mosi[l] !== 1'b0)))
               idle_bad[l] <= idle_bad[l] + 1;
            if (done[l]) done_cnt[l] <= done_cnt[l] + 1;
            sclk_p[l] <= sclk[l];
            cs_p[l]   <= cs[l];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Launch a frame in cycle k and check the state seen in cycle k+1
   task automatic start_frame(input int l, input logic [7:0] tx, input logic [7:0] rep,
                              output int k, output int d0);
      s_reply[l] = rep;
      txd[l]     = tx;
      start[l]   = 1'b1;
      k          = cyc;
      d0         = done_cnt[l];
      step();
      start[l] = 1'b0;
      txd[l]   = 8'($urandom);
      chk($sformatf("cs_k1[%0d]", l), 32'(cs[l]), 32'(0));
      chk($sformatf("busy_k1[%0d]", l), 32'(busy[l]), 32'(1));
      chk($sformatf("sclk_k1[%0d]", l), 32'(sclk[l]), 32'(cpol_of(l)));
      if (!cpha_of(l)) chk($sformatf("mosi_k1[%0d]", l), 32'(mosi[l]), 32'(seq_bit(l, tx, 0)));
   endtask

   task automatic wait_done(input int l);
      int t = 0;
      while (!done[l] && t < 400) begin
         step();
         t++;
      end
      chk($sformatf("done_seen[%0d]", l), 32'(done[l]), 32'(1));
   endtask

   task automatic finish_frame(input int l, input logic [7:0] tx, input logic [7:0] rep,
                               input int k, input int d0);
      wait_done(l);
      chk($sformatf("done_cyc[%0d]", l), 32'(cyc), 32'(k + 1 + 17 * div_of(l)));
      chk($sformatf("rxd[%0d]", l), 32'(rxd[l]), 32'(exp_master(l, tx, rep)));
      chk($sformatf("slave_rx[%0d]", l), 32'(s_rx[l]), 32'(exp_slave(l, tx)));
      chk($sformatf("edges[%0d]", l), 32'(edges[l]), 32'(16));
      chk($sformatf("cs_low[%0d]", l), 32'(cs_low[l]), 32'(17 * div_of(l)));
      chk($sformatf("busy_done[%0d]", l), 32'({cs[l], busy[l]}), 32'(2'b10));
      chk($sformatf("done_cnt[%0d]", l), 32'(done_cnt[l]), 32'(d0 + 1));
   endtask

   task automatic frame(input int l, input logic [7:0] tx, input logic [7:0] rep);
      int k, d0;
      start_frame(l, tx, rep, k, d0);
      finish_frame(l, tx, rep, k, d0);
      step();
      chk($sformatf("done_pulse[%0d]", l), 32'(done[l]), 32'(0));
   endtask

   initial begin
      int k, d0;
      logic [7:0] tx, rep, tx2, rep2;
      rst = 1'b1;
      for (int l = 0; l < NL; l++) begin
         start[l] = 1'b0;
         txd[l]   = 8'h00;
      end
      step();
      step();
      for (int l = 0; l < NL; l++) begin
         chk($sformatf("rst_cs[%0d]", l), 32'(cs[l]), 32'(1));
         chk($sformatf("rst_sclk[%0d]", l), 32'(sclk[l]), 32'(cpol_of(l)));
         chk($sformatf("rst_mosi[%0d]", l), 32'(mosi[l]), 32'(0));
         chk($sformatf("rst_busy[%0d]", l), 32'(busy[l]), 32'(0));
         chk($sformatf("rst_done[%0d]", l), 32'(done[l]), 32'(0));
         chk($sformatf("rst_rxd[%0d]", l), 32'(rxd[l]), 32'(0));
      end
      rst = 1'b0;
      step();

      // Directed frames
      frame(0, 8'hA5, 8'h3C);
      frame(1, 8'h81, 8'hC3);
      frame(2, 8'h01, 8'h96);

      // Random frames on random lanes
      repeat (12) frame($urandom_range(0, NL - 1), 8'($urandom), 8'($urandom));

      // Start pulsed mid-frame is dropped
      tx = 8'($urandom); rep = 8'($urandom);
      start_frame(0, tx, rep, k, d0);
      repeat (4) step();
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      finish_frame(0, tx, rep, k, d0);
      repeat (40) step();
      chk("ignored_start_dones", 32'(done_cnt[0]), 32'(d0 + 1));
      chk("ignored_start_cs", 32'(cs[0]), 32'(1));

      // Start held in the done cycle: back-to-back frame, one CS-high cycle
      tx = 8'($urandom); rep = 8'($urandom);
      tx2 = 8'($urandom); rep2 = 8'($urandom);
      start_frame(1, tx, rep, k, d0);
      finish_frame(1, tx, rep, k, d0);
      s_reply[1] = rep2;
      txd[1]     = tx2;
      start[1]   = 1'b1;
      k          = cyc;
      d0         = done_cnt[1];
      step();
      start[1] = 1'b0;
      chk("b2b_cs_low", 32'(cs[1]), 32'(0));
      chk("b2b_cs_high_cycles", 32'(last_hi[1]), 32'(1));
      finish_frame(1, tx2, rep2, k, d0);

      // Reset mid-frame aborts without a done pulse
      tx = 8'($urandom); rep = 8'($urandom);
      start_frame(0, tx, rep, k, d0);
      repeat (9) step();
      rst = 1'b1;
      step();
      chk("abort_cs", 32'(cs[0]), 32'(1));
      chk("abort_sclk", 32'(sclk[0]), 32'(cpol_of(0)));
      chk("abort_busy", 32'(busy[0]), 32'(0));
      chk("abort_done", 32'(done[0]), 32'(0));
      chk("abort_rxd", 32'(rxd[0]), 32'(0));
      rst = 1'b0;
      repeat (60) step();
      chk("abort_no_done", 32'(done_cnt[0]), 32'(d0));
      chk("abort_rxd_held", 32'(rxd[0]), 32'(0));

      for (int l = 0; l < NL; l++)
         chk($sformatf("idle_levels[%0d]", l), 32'(idle_bad[l]), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_fpga_master_ctrl.md
SPI_FPGA_MASTER_CTRL -- requirements
Module: spi_fpga_master_ctrl

Interface
REQ-001 SHALL have parameter CPHA, default 1: clock phase.
REQ-002 SHALL have parameter CPOL, default 1: SCLK idle level.
REQ-003 SHALL have parameter PACK_LENGTH, default 8: bits per frame, 2..32.
REQ-004 SHALL have parameter PACK_BIT_SEQUENCE_TRANSMIT, default 1: 1 = MSB first, 0 = LSB first.
REQ-005 SHALL have parameter PACK_BIT_SEQUENCE_RECEIVE, default 1: 1 = MSB first, 0 = LSB first.
REQ-006 SHALL have parameter CLK_DIV, default 2: SCLK half-period in IN_CLK cycles, 1..255.
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 SHALL have port IN_CLK, input, 1 bit: system clock; all logic on its rising edge.
REQ-009 SHALL have port IN_RESET, input, 1 bit: synchronous active-high reset.
REQ-010 SHALL have port IN_START, input, 1 bit: frame request.
REQ-011 SHALL have port IN_TRANSMIT_DATA, input, PACK_LENGTH bits: word to send.
REQ-012 SHALL have port MISO, input, 1 bit: serial data from the slave.
REQ-013 SHALL have port SCLK, output, 1 bit: serial clock.
REQ-014 SHALL have port MOSI, output, 1 bit: serial data to the slave.
REQ-015 SHALL have port CS, output, 1 bit: active-low chip select.
REQ-016 SHALL have port OUT_RECEIVE_DATA, output, PACK_LENGTH bits: last received word.
REQ-017 SHALL have port OUT_BUSY, output, 1 bit: high from IN_START acceptance until OUT_DONE.
REQ-018 SHALL have port OUT_DONE, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-019 SHALL implement the FSM IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE; all outputs are registered.
REQ-020 SHALL accept IN_START only in IDLE; the start cycle is k, IN_TRANSMIT_DATA is latched at k, and CS=0 and OUT_BUSY=1 from k+1.
REQ-021 SHALL ignore IN_START outside IDLE, with no queueing.
REQ-022 SHALL stay in SETUP for CLK_DIV cycles, produce 2*PACK_LENGTH SCLK edges spaced CLK_DIV cycles apart in TRANSFER, then stay in HOLD for CLK_DIV cycles; the first edge is at k+1+CLK_DIV.
REQ-023 SHALL hold SCLK at CPOL outside TRANSFER; each odd edge is a leading edge and each even edge is a trailing edge.
REQ-024 SHALL, for CPHA=0, drive bit0 on MOSI at k+1, sample MISO on each leading edge, and shift MOSI on each trailing edge except the last.
REQ-025 SHALL, for CPHA=1, shift MOSI on each leading edge and sample MISO on each trailing edge.
REQ-026 SHALL transmit IN_TRANSMIT_DATA MSB first when PACK_BIT_SEQUENCE_TRANSMIT=1, else LSB first; OUT_RECEIVE_DATA is reordered per PACK_BIT_SEQUENCE_RECEIVE.
REQ-027 SHALL return CS to 1, update OUT_RECEIVE_DATA, and pulse OUT_DONE in cycle k+1+(2*PACK_LENGTH+1)*CLK_DIV; OUT_BUSY falls in the same cycle.
REQ-028 SHALL hold MOSI at 0 in IDLE and hold OUT_RECEIVE_DATA until the next OUT_DONE.
REQ-029 SHALL accept IN_START asserted in the OUT_DONE cycle, so back-to-back frames keep CS high for at least one cycle.

Reset
REQ-030 SHALL, one cycle after IN_RESET high, force state=IDLE, SCLK=CPOL, CS=1, MOSI=0, OUT_RECEIVE_DATA=0, OUT_BUSY=0, OUT_DONE=0 and clear all counters.
REQ-031 SHALL abort a frame on reset mid-frame with no OUT_DONE pulse and no update of OUT_RECEIVE_DATA; IN_RESET has priority over IN_START.

Configuration
REQ-032 SHALL, with macro SPI_FPGA_MASTER_LOOPBACK_EN defined, sample the internal MOSI instead of the MISO pin, so OUT_RECEIVE_DATA equals the transmitted word after any bit reordering.
REQ-033 SHALL, without SPI_FPGA_MASTER_LOOPBACK_EN, sample MISO with no loopback logic present.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE, SETUP, TRANSFER, HOLD) and the mode constants (CPHA/CPOL pairs) in shared package spi_fpga_pkg.
REQ-035 SHALL use one sub-module, spi_fpga_sclk_gen, as the CLK_DIV divider emitting edge-strobe, leading/trailing flag and edge count.

Verification
REQ-036 SHALL cover: CPHA=1, CPOL=1, N=8, DIV=2, TX=0xA5 with a slave model replying 0x3C -> 16 SCLK edges, CS low for 34 cycles, OUT_DONE at k+35, OUT_RECEIVE_DATA=0x3C.
REQ-037 SHALL cover: CPHA=0, CPOL=0, TX=0x81 -> MOSI=1 at k+1 before the first rising edge, SCLK idle 0, slave receives 0x81.
REQ-038 SHALL cover: PACK_BIT_SEQUENCE_TRANSMIT=0, TX=0x01 -> MOSI high only during bit slot 0; slave configured MSB-first receives 0x80.
REQ-039 SHALL cover: IN_START pulsed at k+5 during a frame -> ignored, exactly one OUT_DONE; IN_START held in the OUT_DONE cycle -> second frame with CS high for exactly one cycle.
REQ-040 SHALL cover: IN_RESET at k+10 -> next cycle CS=1, SCLK=CPOL, OUT_BUSY=0, no OUT_DONE, OUT_RECEIVE_DATA=0.
REQ-041 SHALL cover: SPI_FPGA_MASTER_LOOPBACK_EN defined, MISO tied 0, TX=0x5A -> OUT_RECEIVE_DATA=0x5A.
